// File: rtl/qpsk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : qpsk_pkg                                                 |
// | Purpose    : Shared constants for the QPSK receiver control blocks:   |
// |              phase-search FSM state encoding, default settle/window/  |
// |              threshold values and a small elaboration helper.         |
// | Revision   : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package qpsk_pkg;

  // Default phase-search configuration
  localparam int UPSAMPLE_DEF   = 4;
  localparam int SETTLE_SYM_DEF = 32;
  localparam int WIN_LOG2_DEF   = 10;
  localparam int ERR_W_DEF      = 11;
  localparam int ERR_THRESH_DEF = 16;

  // Phase-search FSM encoding
  localparam int          ST_W       = 3;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_SETTLE  = 3'd1;
  localparam logic [2:0]  ST_MEASURE = 3'd2;
  localparam logic [2:0]  ST_EVAL    = 3'd3;
  localparam logic [2:0]  ST_LOCK    = 3'd4;
  localparam logic [2:0]  ST_FAIL    = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sym_window_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : sym_window_ctr                                           |
// | Purpose    : Strobe-driven symbol window counter with a saturating    |
// |              error accumulator. Counts len strobes, then wraps its    |
// |              window count; the error total is held until cleared.    |
// | Ports      : clk, rst    clock / synchronous active-high reset        |
// |              clr         clear both counters (beats a same-cycle      |
// |                          strobe)                                      |
// |              sym_en      gated symbol strobe                          |
// |              err         symbol error, valid with sym_en              |
// |              len         window length in strobes (>= 1)              |
// |              err_cnt     registered error total                       |
// |              err_next    error total including this cycle's strobe    |
// |              done        comb pulse on the len-th strobe              |
// | Revision   : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module sym_window_ctr
  import qpsk_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int ERR_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sym_en,
  input  logic             err,
  input  logic [CNT_W-1:0] len,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] err_next,
  output logic             done
);

  logic [CNT_W-1:0] win_cnt;

  always_comb begin
    err_next = err_cnt;
    if (sym_en && err && (err_cnt != {ERR_W{1'b1}}))
      err_next = err_cnt + 1'b1;
  end

  assign done = sym_en && (win_cnt == (len - 1'b1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (sym_en) begin
      win_cnt <= done ? '0 : (win_cnt + 1'b1);
      err_cnt <= err_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : phase_search_ctrl                                        |
// | Purpose    : Startup sampling-phase search for the QPSK receiver.     |
// |              Sweeps phase 0..3, scores each phase over a window of    |
// |              2^WIN_LOG2 symbols after SETTLE_SYM flush symbols, and   |
// |              locks on the lowest-error phase (lower phase on ties) or |
// |              flags failure when the best count exceeds ERR_THRESH.    |
// | Ports      : clk, rst    clock / synchronous active-high reset        |
// |              i_start     pulse: begin search (ignored while busy)     |
// |              i_sym_en    symbol strobe, 1 clk in UPSAMPLE             |
// |              i_err       symbol error, valid with i_sym_en            |
// |              o_phase     rx sampling phase select                     |
// |              o_rx_en     rx enable                                    |
// |              o_ber_en    high while errors are being scored           |
// |              o_busy      search in progress                           |
// |              o_locked    locked, o_phase final                        |
// |              o_fail      sweep done, best count above threshold       |
// |              o_best_err  best window error count so far               |
// | Config     : PHASE_SEARCH_RELOCK_EN - keep measuring windows while    |
// |              locked; restart the sweep when a window exceeds          |
// |              ERR_THRESH, otherwise report that window's count.        |
// | Revision   : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module phase_search_ctrl
  import qpsk_pkg::*;
#(
  parameter int UPSAMPLE   = UPSAMPLE_DEF,
  parameter int SETTLE_SYM = SETTLE_SYM_DEF,
  parameter int WIN_LOG2   = WIN_LOG2_DEF,
  parameter int ERR_W      = ERR_W_DEF,
  parameter int ERR_THRESH = ERR_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sym_en,
  input  logic             i_err,
  output logic [1:0]       o_phase,
  output logic             o_rx_en,
  output logic             o_ber_en,
  output logic             o_busy,
  output logic             o_locked,
  output logic             o_fail,
  output logic [ERR_W-1:0] o_best_err
);

`ifdef PHASE_SEARCH_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  localparam int               CNT_W      = max_int($clog2(SETTLE_SYM + 1), WIN_LOG2 + 1);
  localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_SYM);
  localparam logic [CNT_W-1:0] WIN_LEN    = CNT_W'(2 ** WIN_LOG2);
  localparam logic [ERR_W-1:0] THRESH     = ERR_W'(ERR_THRESH);

  logic [ST_W-1:0]  state, state_nx;
  logic [1:0]       phase_nx, best_ph, best_ph_nx;
  logic [ERR_W-1:0] best_err_nx;
  logic             ctr_clr, ctr_en, ctr_done;
  logic [CNT_W-1:0] ctr_len;
  logic [ERR_W-1:0] err_cnt, err_next;

  sym_window_ctr #(
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .sym_en   (i_sym_en && ctr_en),
    .err      (i_err),
    .len      (ctr_len),
    .err_cnt  (err_cnt),
    .err_next (err_next),
    .done     (ctr_done)
  );

  always_comb begin
    state_nx    = state;
    phase_nx    = o_phase;
    best_err_nx = o_best_err;
    best_ph_nx  = best_ph;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    ctr_len     = WIN_LEN;

    case (state)
      ST_IDLE, ST_FAIL: begin
        if (i_start) begin
          state_nx    = ST_SETTLE;
          phase_nx    = 2'd0;
          best_err_nx = '1;
          best_ph_nx  = 2'd0;
          ctr_clr     = 1'b1;
        end
      end

      ST_SETTLE: begin
        ctr_en  = 1'b1;
        ctr_len = SETTLE_LEN;
        // Settle-period errors are discarded by clearing on the way out
        if (ctr_done) begin
          state_nx = ST_MEASURE;
          ctr_clr  = 1'b1;
        end
      end

      ST_MEASURE: begin
        ctr_en = 1'b1;
        // Counter holds the final total (last strobe included) for EVAL
        if (ctr_done)
          state_nx = ST_EVAL;
      end

      ST_EVAL: begin
        ctr_clr = 1'b1;
        // Strict compare: an equal count never displaces a lower phase
        if (err_cnt < o_best_err) begin
          best_err_nx = err_cnt;
          best_ph_nx  = o_phase;
        end
        if (o_phase != 2'd3) begin
          phase_nx = o_phase + 2'd1;
          state_nx = ST_SETTLE;
        end else begin
          phase_nx = best_ph_nx;
          state_nx = (best_err_nx <= THRESH) ? ST_LOCK : ST_FAIL;
        end
      end

      ST_LOCK: begin
        ctr_en = RELOCK;
        if (i_start || (RELOCK && ctr_done && (err_next > THRESH))) begin
          state_nx    = ST_SETTLE;
          phase_nx    = 2'd0;
          best_err_nx = '1;
          best_ph_nx  = 2'd0;
          ctr_clr     = 1'b1;
        end else if (RELOCK && ctr_done) begin
          // Window ends on this strobe: report it and start the next one
          best_err_nx = err_next;
          ctr_clr     = 1'b1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      o_phase    <= 2'd0;
      best_ph    <= 2'd0;
      o_best_err <= '1;
      o_rx_en    <= 1'b0;
      o_ber_en   <= 1'b0;
      o_busy     <= 1'b0;
      o_locked   <= 1'b0;
      o_fail     <= 1'b0;
    end else begin
      state      <= state_nx;
      o_phase    <= phase_nx;
      best_ph    <= best_ph_nx;
      o_best_err <= best_err_nx;
      o_rx_en    <= (state_nx != ST_IDLE) && (state_nx != ST_FAIL);
      o_ber_en   <= (state_nx == ST_MEASURE) || (RELOCK && (state_nx == ST_LOCK));
      o_busy     <= (state_nx == ST_SETTLE) || (state_nx == ST_MEASURE) ||
                    (state_nx == ST_EVAL);
      o_locked   <= (state_nx == ST_LOCK);
      o_fail     <= (state_nx == ST_FAIL);
    end
  end

  // EVAL takes one clock between the last window strobe and the next
  // strobe; with strobes at least two clocks apart none can land there.
  always_ff @(posedge clk) begin
    if (!rst && (UPSAMPLE > 1))
      assert (!((state == ST_EVAL) && i_sym_en));
  end

endmodule
`default_nettype wire
